clock_edit_controller: RTL

Parametrised successor to the clock's mode/display controller. Decodes three synchronous push-button levels (display, mode, inc) into a page selection (time, date, …), an edit-field walk across the current page, a per-field blink mask and a one-cycle increment strobe for the counters. The block adds an idle timeout and a tick-driven blink generator. It sits between the button front-end and the second…year counter banks and the display mux.

---
 rtl/clock_edit_controller.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/clock_edit_controller.sv
// Page/edit-field controller for the clock: decodes the display/mode/inc buttons into a
// page select, one-hot edit target, per-field blink mask and an increment strobe.
module clock_edit_controller #(
  parameter int unsigned NUM_PAGES = 2,
  parameter int unsigned FIELDS    = 3,
  parameter int unsigned BLINK_DIV = 4,
  parameter int unsigned TIMEOUT   = 16,
  localparam int unsigned PAGE_W   = (NUM_PAGES > 1) ? $clog2(NUM_PAGES) : 1,
  localparam int unsigned SEL_W    = NUM_PAGES * FIELDS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tick,
  input  logic              display,
  input  logic              mode,
  input  logic              inc,
  output logic [PAGE_W-1:0] page,
  output logic              edit_active,
  output logic [SEL_W-1:0]  field_sel,
  output logic [FIELDS-1:0] blink,
  output logic              inc_pulse
);

  localparam int unsigned FIELD_W   = (FIELDS > 1) ? $clog2(FIELDS) : 1;
  localparam int unsigned BCNT_W    = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int unsigned IDLE_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int unsigned IDLE_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  typedef enum logic [0:0] {
    VIEW = 1'b0,
    EDIT = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [PAGE_W-1:0]   page_q, page_d;
  logic [FIELD_W-1:0]  field_q, field_d;
  logic [IDLE_W-1:0]   idle_q, idle_d;
  logic [BCNT_W-1:0]   bcnt_q, bcnt_d;
  logic                phase_q, phase_d;
  logic [2:0]          prev_q, prev_d;
  logic                inc_pulse_q, inc_pulse_d;
  logic [SEL_W-1:0]    field_sel_q, field_sel_d;
  logic [FIELDS-1:0]   blink_q, blink_d;

  logic [2:0] rise;
  logic       disp_rise, mode_rise, inc_rise, any_rise;
  logic       go_view, restart;

  // prev resets high so a button held across reset release is not seen as a press
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= VIEW;
      page_q      <= '0;
      field_q     <= '0;
      idle_q      <= '0;
      bcnt_q      <= '0;
      phase_q     <= 1'b0;
      prev_q      <= 3'b111;
      inc_pulse_q <= 1'b0;
      field_sel_q <= '0;
      blink_q     <= '0;
    end else begin
      state_q     <= state_d;
      page_q      <= page_d;
      field_q     <= field_d;
      idle_q      <= idle_d;
      bcnt_q      <= bcnt_d;
      phase_q     <= phase_d;
      prev_q      <= prev_d;
      inc_pulse_q <= inc_pulse_d;
      field_sel_q <= field_sel_d;
      blink_q     <= blink_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    page_d      = page_q;
    field_d     = field_q;
    idle_d      = idle_q;
    bcnt_d      = bcnt_q;
    phase_d     = phase_q;
    prev_d      = {display, mode, inc};
    inc_pulse_d = 1'b0;
    field_sel_d = '0;
    blink_d     = '0;
    go_view     = 1'b0;
    restart     = 1'b0;

    rise      = {display, mode, inc} & ~prev_q;
    disp_rise = rise[2];
    mode_rise = rise[1];
    inc_rise  = rise[0];
    any_rise  = |rise;

    unique case (state_q)
      VIEW: begin
        if (mode_rise) begin
          state_d = EDIT;
          restart = 1'b1;
        end else if (disp_rise) begin
          page_d = (page_q == PAGE_W'(NUM_PAGES - 1)) ? '0 : page_q + PAGE_W'(1);
        end
      end
      EDIT: begin
        if (disp_rise) begin
          go_view = 1'b1;
        end else if (mode_rise) begin
          if (field_q == FIELD_W'(FIELDS - 1)) begin
            go_view = 1'b1;
          end else begin
            field_d = field_q + FIELD_W'(1);
            restart = 1'b1;
          end
        end else begin
          inc_pulse_d = inc_rise;
          // a button rise clears the idle count and beats a simultaneous tick
          if (any_rise) begin
            idle_d = '0;
          end else if (tick && (TIMEOUT != 0)) begin
            if (idle_q == IDLE_W'(IDLE_LAST)) begin
              go_view = 1'b1;
            end else begin
              idle_d = idle_q + IDLE_W'(1);
            end
          end
          if (tick) begin
            if (bcnt_q == BCNT_W'(BLINK_DIV - 1)) begin
              bcnt_d  = '0;
              phase_d = ~phase_q;
            end else begin
              bcnt_d = bcnt_q + BCNT_W'(1);
            end
          end
        end
      end
      default: go_view = 1'b1;
    endcase

    if (restart) begin
      idle_d  = '0;
      bcnt_d  = '0;
      phase_d = 1'b1;
    end

    if (go_view) begin
      state_d     = VIEW;
      field_d     = '0;
      idle_d      = '0;
      bcnt_d      = '0;
      phase_d     = 1'b0;
      inc_pulse_d = 1'b0;
    end

    // output decode from next state so the registered outputs track the state with no extra lag
    for (int unsigned p = 0; p < NUM_PAGES; p++) begin
      for (int unsigned f = 0; f < FIELDS; f++) begin
        if ((state_d == EDIT) && (page_d == PAGE_W'(p)) && (field_d == FIELD_W'(f))) begin
          field_sel_d[p * FIELDS + f] = 1'b1;
        end
      end
    end
    for (int unsigned f = 0; f < FIELDS; f++) begin
      blink_d[f] = (state_d == EDIT) && (field_d == FIELD_W'(f)) && phase_d;
    end
  end

  assign page        = page_q;
  assign edit_active = (state_q == EDIT);
  assign field_sel   = field_sel_q;
  assign blink       = blink_q;
  assign inc_pulse   = inc_pulse_q;

endmodule
